// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, condition codes, ALU ops, CC layout.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_t;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    localparam logic [63:0] CONST_P8 = 64'd8;
    localparam logic [63:0] CONST_M8 = 64'hFFFF_FFFF_FFFF_FFF8;

endpackage

// File: rtl/alu_.sv
// 64-bit ALU: out = inp1 OP inp2, plus ZF/SF/OF flags in CC bit order.
module alu_
    import y86_pkg::*;
(
    input  logic [63:0] inp1,
    input  logic [63:0] inp2,
    input  alu_op_t     op,
    output logic [63:0] out,
    output logic [2:0]  flags
);

    // Datapath and flag generation; OF only meaningful for add/sub.
    always_comb begin
        out = 64'd0;
        flags = 3'b000;
        case (op)
            ALU_ADD: begin
                out = inp1 + inp2;
                flags[CC_OF] = (inp1[63] == inp2[63]) && (out[63] != inp1[63]);
            end
            ALU_SUB: begin
                out = inp1 - inp2;
                flags[CC_OF] = (inp1[63] != inp2[63]) && (out[63] != inp1[63]);
            end
            ALU_AND: out = inp1 & inp2;
            ALU_XOR: out = inp1 ^ inp2;
            default: out = 64'd0;
        endcase
        flags[CC_ZF] = (out == 64'd0);
        flags[CC_SF] = out[63];
    end

endmodule

// File: rtl/cond_eval.sv
// Branch / conditional-move condition decode from function code and flags.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cond
);

    logic zf, sf, of;
    assign zf = cc[CC_ZF];
    assign sf = cc[CC_SF];
    assign of = cc[CC_OF];

    // Raw condition; the caller decides whether the instruction uses it.
    always_comb begin
        cond = 1'b0;
        case (ifun)
            C_ALWAYS: cond = 1'b1;
            C_LE:     cond = (sf ^ of) | zf;
            C_L:      cond = sf ^ of;
            C_E:      cond = zf;
            C_NE:     cond = ~zf;
            C_GE:     cond = ~(sf ^ of);
            C_G:      cond = ~(sf ^ of) & ~zf;
            default:  cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand/op select, CC register, condition evaluation.
module execute_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        stat_ok,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic [63:0] valE,
    output logic        Cnd,
    output logic [2:0]  cc
);

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    alu_op_t     alu_op;
    logic [2:0]  alu_flags;
    logic        opq_valid;
    logic        cc_wr;
    logic        cond_raw;

    assign opq_valid = (icode == OPQ) && (ifun <= 4'd3);

    // Operand and operation select; invalid OPQ functions zero both operands.
    always_comb begin
        alu_a  = 64'd0;
        alu_b  = 64'd0;
        alu_op = ALU_ADD;
        case (icode)
            RRMOVQ: alu_a = valA;
            IRMOVQ: alu_a = valC;
            RMMOVQ, MRMOVQ: begin
                alu_a = valC;
                alu_b = valB;
            end
            OPQ: begin
                if (opq_valid) begin
                    alu_a  = valA;
                    alu_b  = valB;
                    alu_op = alu_op_t'(ifun[1:0]);
                end
            end
            CALL, PUSHQ: begin
                alu_a = CONST_M8;
                alu_b = valB;
            end
            RET, POPQ: begin
                alu_a = CONST_P8;
                alu_b = valB;
            end
            default: begin
                alu_a = 64'd0;
                alu_b = 64'd0;
            end
        endcase
    end

    alu_ u_alu (
        .inp1  (alu_b),
        .inp2  (alu_a),
        .op    (alu_op),
        .out   (valE),
        .flags (alu_flags)
    );

    assign cc_wr = en && stat_ok && opq_valid;

    // Architectural condition codes, written only by a valid, enabled OPQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc <= CC_RESET;
        end else if (cc_wr) begin
            cc <= alu_flags;
        end
    end

    cond_eval u_cond (
        .ifun (ifun),
        .cc   (cc),
        .cond (cond_raw)
    );

    // Only jumps and conditional moves consume the condition.
    always_comb begin
        Cnd = 1'b0;
        if ((icode == JXX) || (icode == RRMOVQ)) begin
            Cnd = cond_raw;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        stat_ok;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        Cnd;
    logic [2:0]  cc;

    int vectors;
    int miscompares;

    execute_stage dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .stat_ok (stat_ok),
        .icode   (icode),
        .ifun    (ifun),
        .valA    (valA),
        .valB    (valB),
        .valC    (valC),
        .valE    (valE),
        .Cnd     (Cnd),
        .cc      (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one instruction just after a rising edge and let combinational outputs settle.
    task automatic drive(input logic e, input logic ok, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        en = e;
        stat_ok = ok;
        icode = ic;
        ifun = fn;
        valA = a;
        valB = b;
        valC = c;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        check_vec("rst_cc", {61'd0, cc}, 64'h4);
        check_vec("rst_jle", {63'd0, Cnd}, 64'd1);
        drive(1'b1, 1'b1, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
        check_vec("rst_jne", {63'd0, Cnd}, 64'd0);
        rst = 1'b0;
        next_cycle();

        // subq: 3 - 5
        drive(1'b1, 1'b1, 4'h6, 4'h1, 64'd5, 64'd3, 64'd0);
        check_vec("subq_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
        next_cycle();
        check_vec("subq_cc", {61'd0, cc}, 64'h2);
        drive(1'b1, 1'b1, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        check_vec("jl", {63'd0, Cnd}, 64'd1);
        drive(1'b1, 1'b1, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
        check_vec("jge", {63'd0, Cnd}, 64'd0);
        drive(1'b1, 1'b1, 4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
        check_vec("jg", {63'd0, Cnd}, 64'd0);

        // addq overflow
        drive(1'b1, 1'b1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        check_vec("addq_valE", valE, 64'h8000_0000_0000_0000);
        next_cycle();
        check_vec("addq_cc", {61'd0, cc}, 64'h3);

        // andq to zero clears OF
        drive(1'b1, 1'b1, 4'h6, 4'h2, 64'hF0, 64'h0F, 64'd0);
        check_vec("andq_valE", valE, 64'd0);
        next_cycle();
        check_vec("andq_cc", {61'd0, cc}, 64'h4);

        // xorq blocked by en, stat_ok, invalid ifun
        drive(1'b0, 1'b1, 4'h6, 4'h3, 64'hF0, 64'h0F, 64'd0);
        check_vec("xor_en0_valE", valE, 64'hFF);
        next_cycle();
        check_vec("xor_en0_cc", {61'd0, cc}, 64'h4);
        drive(1'b1, 1'b0, 4'h6, 4'h3, 64'hF0, 64'h0F, 64'd0);
        next_cycle();
        check_vec("xor_stat0_cc", {61'd0, cc}, 64'h4);
        drive(1'b1, 1'b1, 4'h6, 4'h5, 64'hF0, 64'h0F, 64'd0);
        check_vec("opq_if5_valE", valE, 64'd0);
        next_cycle();
        check_vec("opq_if5_cc", {61'd0, cc}, 64'h4);

        // address arithmetic, ifun=0 so Cnd gating is exercised
        drive(1'b1, 1'b1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
        check_vec("pushq_valE", valE, 64'hF8);
        check_vec("pushq_cnd", {63'd0, Cnd}, 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
        check_vec("popq_valE", valE, 64'h108);
        check_vec("popq_cnd", {63'd0, Cnd}, 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 4'h5, 4'h0, 64'd0, 64'h20, 64'h10);
        check_vec("mrmovq_valE", valE, 64'h30);
        check_vec("mrmovq_cnd", {63'd0, Cnd}, 64'd0);
        next_cycle();
        drive(1'b1, 1'b1, 4'h3, 4'h0, 64'h55, 64'h77, 64'h1234);
        check_vec("irmovq_valE", valE, 64'h1234);
        check_vec("irmovq_cnd", {63'd0, Cnd}, 64'd0);
        next_cycle();
        check_vec("addr_cc", {61'd0, cc}, 64'h4);

        // cmovl with cc=100 is false, cmove true
        drive(1'b1, 1'b1, 4'h2, 4'h2, 64'hABCD, 64'd0, 64'd0);
        check_vec("cmovl_cnd", {63'd0, Cnd}, 64'd0);
        check_vec("cmovl_valE", valE, 64'hABCD);
        drive(1'b1, 1'b1, 4'h2, 4'h3, 64'hABCD, 64'd0, 64'd0);
        check_vec("cmove_cnd", {63'd0, Cnd}, 64'd1);

        // async reset mid-cycle after cc=011
        drive(1'b1, 1'b1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        next_cycle();
        check_vec("pre_rst_cc", {61'd0, cc}, 64'h3);
        #1;
        rst = 1'b1;
        #1;
        check_vec("async_rst_cc", {61'd0, cc}, 64'h4);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'h2, 4'h0, 64'h1357_9BDF, 64'hFFFF, 64'h2222);
        check_vec("rrmovq_cnd", {63'd0, Cnd}, 64'd1);
        check_vec("rrmovq_valE", valE, 64'h1357_9BDF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the sequential Y86-64 processor. It sits between decode, which supplies icode/ifun/valA/valB/valC, and the memory and writeback stages, which consume valE and Cnd. It selects the ALU operands and operation, instantiates the existing 64-bit ALU, holds the architectural condition-code register, and evaluates branch and conditional-move conditions.

## Interface
- No parameters. Data width is fixed at 64.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: stage enable; the CC register updates only when high.
- `stat_ok` in 1: high when the current instruction has no exception (not HLT, ADR or INS).
- `icode` in 4: instruction code.
- `ifun` in 4: function code.
- `valA` in 64: operand A from decode.
- `valB` in 64: operand B from decode.
- `valC` in 64: immediate or displacement.
- `valE` out 64: ALU result, combinational.
- `Cnd` out 1: condition result, combinational, computed from the registered CC.
- `cc` out 3: registered flags; [2]=ZF, [1]=SF, [0]=OF.

## Operation
- Operand and op select, with ALU inp1=aluB and inp2=aluA, so that valE = aluB OP aluA:
  - RRMOVQ/CMOVXX (2): aluA=valA, aluB=0, op add.
  - IRMOVQ (3): aluA=valC, aluB=0, add.
  - RMMOVQ (4) and MRMOVQ (5): aluA=valC, aluB=valB, add.
  - OPQ (6): aluA=valA, aluB=valB, op=ifun[1:0] (0 add, 1 sub, 2 and, 3 xor).
  - CALL (8) and PUSHQ (A): aluA=-8, aluB=valB, add.
  - RET (9) and POPQ (B): aluA=+8, aluB=valB, add.
  - Any other icode: aluA=aluB=0, add, so valE=0.
- OPQ with ifun>3 is invalid: valE=0 and no CC update.
- CC update, written on the clock edge, requires all of: en=1, stat_ok=1, icode=OPQ, ifun≤3. When set, cc takes the ALU flags.
  - ZF = result==0.
  - SF = result[63].
  - OF = signed overflow for add/sub, forced to 0 for and/xor.
- Cnd applies only when icode is JXX (7) or CMOVXX (2); for every other icode Cnd=0. Decode on ifun:
  - 0 always: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - ifun>6: 0.
- Arithmetic wraps modulo 2^64. The constants ±8 are 64-bit sign-extended.

## Timing
- valE and Cnd are combinational from inputs and the current cc, with zero-cycle latency.
- The cc register is the only state. A new value is visible on the cycle after the updating OPQ.
- Cnd for an instruction always uses flags from earlier instructions, never from its own ALU result.
- Reset value: cc=3'b100 (ZF=1, SF=0, OF=0). valE and Cnd then follow their inputs combinationally.
- rst asserted mid-cycle clears cc immediately, whatever en or icode are. Deassertion takes effect at the next rising edge.
- en=0 or stat_ok=0 holds cc with no exceptions. valE and Cnd are still driven.

## Structure
- Shared package `y86_pkg`, holding:
  - icode constants: HALT…POPQ.
  - Condition ifun constants: C_ALWAYS…C_G.
  - ALU op codes: ALU_ADD/SUB/AND/XOR.
  - CC bit indices: CC_ZF=2, CC_SF=1, CC_OF=0.
  - Reset value CC_RESET=3'b100.
- Sub-modules:
  - Reuse the existing `alu_` for datapath and flag generation.
  - New combinational sub-module `cond_eval` (inputs ifun and cc; output the raw condition). The icode gating stays in `execute_stage`.

## Test plan
- Reset with icode=7, ifun=1 (jle) → cc=100, Cnd=1. The same state with ifun=4 (jne) → Cnd=0.
- OPQ subq, valB=3, valA=5, en=1, stat_ok=1 → valE=0xFFFF_FFFF_FFFF_FFFE. After the edge cc=010. Then jl → Cnd=1, jge → Cnd=0, jg → 0.
- OPQ addq, valB=0x7FFF_FFFF_FFFF_FFFF, valA=1 → valE=0x8000_0000_0000_0000, next cc=011. Then andq with valA=0xF0, valB=0x0F → valE=0, next cc=100 (OF cleared).
- OPQ xorq producing a nonzero result with en=0, then again with stat_ok=0, then with ifun=5 → cc unchanged in every case. The ifun=5 case also gives valE=0.
- Address arithmetic:
  - pushq valB=0x100 → valE=0xF8.
  - popq valB=0x100 → valE=0x108.
  - mrmovq valC=0x10, valB=0x20 → 0x30.
  - irmovq valC=0x1234 → 0x1234.
  - cc stays unchanged throughout; Cnd=0 for all of these.
- With cc=011 after an OPQ, assert rst asynchronously between clock edges → cc reads 100 before the next edge. rrmovq (ifun=0) → Cnd=1, valE=valA.
